ofifo: RTL

Output FIFO between the MAC array and the accumulate/ReLU stage. Each of the `col` array columns produces psums at its own time, so each column writes its own FIFO lane independently. Reads pop one word from every lane in the same cycle, so a full `col`-wide psum row is delivered to the accumulate/ReLU stage in column alignment.

---
 rtl/ofifo_pkg.sv | 14 +
 rtl/ofifo_lane.sv | 72 +++++++
 rtl/ofifo.sv | 74 +++++++
 3 files changed

// File: rtl/ofifo_pkg.sv
// ============================================================================
// ofifo_pkg : shared sizing for the MAC-array output FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

package ofifo_pkg;
   localparam int BW    = 16;
   localparam int COL   = 8;
   localparam int DEPTH = 64;
   localparam int PTR_W = $clog2(DEPTH);
endpackage

`default_nettype wire

// File: rtl/ofifo_lane.sv
// ============================================================================
// ofifo_lane : one independent circular-buffer lane of the output FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module ofifo_lane
   import ofifo_pkg::*;
#(
   parameter int DATA_W     = BW,
   parameter int LANE_DEPTH = DEPTH
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr_en,
   input  logic              i_rd_en,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_wr_drop
);

   localparam int                c_PTR_W    = $clog2(LANE_DEPTH);
   localparam logic [c_PTR_W:0]  c_FULL_CNT = (c_PTR_W+1)'(LANE_DEPTH);
   localparam logic [c_PTR_W:0]  c_CNT_ONE  = (c_PTR_W+1)'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

   logic [DATA_W-1:0]  r_mem [LANE_DEPTH];
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_wr_ok;
   logic               w_rd_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_FULL_CNT);
   // Fullness is judged before this cycle's pop, so a concurrent read never rescues a write
   assign w_wr_ok   = i_wr_en & ~o_full;
   assign w_rd_ok   = i_rd_en & ~o_empty;
   assign o_wr_drop = i_wr_en & o_full;
   assign o_rd_data = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_rd_ok) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/ofifo.sv
// ============================================================================
// ofifo : per-column write lanes, row-aligned pop into a registered output
// Rev 1.0
// ============================================================================
`default_nettype none

module ofifo
   import ofifo_pkg::*;
#(
   parameter int bw    = BW,
   parameter int col   = COL,
   parameter int depth = DEPTH
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [col-1:0]    wr,
   input  logic [bw*col-1:0] in,
   input  logic              rd,
   output logic [bw*col-1:0] out,
   output logic              o_valid,
   output logic              o_full,
   output logic              o_ready,
   output logic              o_overflow
);

   logic [col-1:0]    w_empty;
   logic [col-1:0]    w_full;
   logic [col-1:0]    w_drop;
   logic [bw*col-1:0] w_rdata;
   logic              w_rd_en;
   logic [bw*col-1:0] r_out;
   logic              r_overflow;

   assign o_valid    = ~|w_empty;
   assign o_full     = |w_full;
   assign o_ready    = ~o_full;
   assign w_rd_en    = rd & o_valid;
   assign out        = r_out;
   assign o_overflow = r_overflow;

   generate
      for (genvar g = 0; g < col; g++) begin : g_lane
         ofifo_lane #(
            .DATA_W     (bw),
            .LANE_DEPTH (depth)
         ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_wr_en   (wr[g]),
            .i_rd_en   (w_rd_en),
            .i_data    (in[g*bw +: bw]),
            .o_rd_data (w_rdata[g*bw +: bw]),
            .o_empty   (w_empty[g]),
            .o_full    (w_full[g]),
            .o_wr_drop (w_drop[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_rd_en) begin
            r_out <= w_rdata;
         end
         r_overflow <= r_overflow | (|w_drop);
      end
   end

endmodule

`default_nettype wire
